// File: rtl/phase_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : phase_timer                                              |
// | Description : Per-phase dwell timer for a traffic-light sequencer.     |
// |               A one-second prescaler drives a down-counter that is     |
// |               reloaded on every phase change. A single-cycle advance   |
// |               pulse (mux_out) is emitted when the dwell expires.       |
// | Options     : PHASE_TIMER_FAST_SIM_EN - forces the prescaler divisor   |
// |               to 4 so that simulations run quickly.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module phase_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int OFF_S    = 2,
   parameter int RED_S    = 30,
   parameter int GREEN_S  = 25,
   parameter int YELLOW_S = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] state,
   output logic       mux_out,
   output logic       sec_tick,
   output logic [7:0] remaining
);

`ifdef PHASE_TIMER_FAST_SIM_EN
   // TICK_DIV is still referenced so the parameter stays meaningful in both builds.
   localparam int C_DIV = (TICK_DIV > 0) ? 4 : 4;
`else
   localparam int C_DIV = TICK_DIV;
`endif

   localparam int              C_PW   = (C_DIV > 2) ? $clog2(C_DIV) : 1;
   localparam logic [C_PW-1:0] C_LAST = C_PW'(C_DIV - 1);

   // Durations are clamped to 1..255 so a phase always lasts at least one tick.
   function automatic logic [7:0] sat_dur(input int secs);
      logic [7:0] r;
      if (secs <= 0) begin
         r = 8'd1;
      end else if (secs > 255) begin
         r = 8'd255;
      end else begin
         r = secs[7:0];
      end
      return r;
   endfunction

   localparam logic [7:0] C_OFF_DUR    = sat_dur(OFF_S);
   localparam logic [7:0] C_RED_DUR    = sat_dur(RED_S);
   localparam logic [7:0] C_GREEN_DUR  = sat_dur(GREEN_S);
   localparam logic [7:0] C_YELLOW_DUR = sat_dur(YELLOW_S);

   logic [C_PW-1:0] presc_q, presc_d;
   logic            sec_tick_q, sec_tick_d;
   logic            mux_out_q, mux_out_d;
   logic [1:0]      state_q, state_d;
   logic [7:0]      remaining_q, remaining_d;
   logic [7:0]      dur_sel;
   logic            phase_chg;

   // Dwell lookup for the incoming phase.
   always_comb begin
      dur_sel = C_OFF_DUR;
      case (state)
         2'b00:   dur_sel = C_OFF_DUR;
         2'b01:   dur_sel = C_RED_DUR;
         2'b10:   dur_sel = C_GREEN_DUR;
         default: dur_sel = C_YELLOW_DUR;
      endcase
   end

   // Next-state: phase change reloads and restarts the second, otherwise count down.
   always_comb begin
      presc_d     = presc_q;
      sec_tick_d  = 1'b0;
      mux_out_d   = 1'b0;
      remaining_d = remaining_q;
      state_d     = state;
      phase_chg   = (state != state_q);

      if (phase_chg) begin
         // Reload wins over any pending tick, so no decrement and no pulse here.
         remaining_d = dur_sel;
         presc_d     = '0;
      end else begin
         if (enable) begin
            if (presc_q == C_LAST) begin
               presc_d    = '0;
               sec_tick_d = 1'b1;
            end else begin
               presc_d = presc_q + C_PW'(1);
            end
         end
         // A registered tick was earned while enabled, so it is consumed even if
         // enable has just dropped. Ticks are >= 2 cycles apart, which keeps
         // mux_out pulses separated by at least one low cycle.
         if (sec_tick_q) begin
            if (remaining_q > 8'd1) begin
               remaining_d = remaining_q - 8'd1;
            end else if (remaining_q == 8'd1) begin
               remaining_d = 8'd0;
               mux_out_d   = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q     <= '0;
         sec_tick_q  <= 1'b0;
         mux_out_q   <= 1'b0;
         state_q     <= 2'b00;
         remaining_q <= C_OFF_DUR;
      end else begin
         presc_q     <= presc_d;
         sec_tick_q  <= sec_tick_d;
         mux_out_q   <= mux_out_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   assign mux_out   = mux_out_q;
   assign sec_tick  = sec_tick_q;
   assign remaining = remaining_q;

endmodule
`default_nettype wire

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per one-second tick; legal range is 2 or greater.
REQ-002 The block SHALL have parameter OFF_S, default 2, meaning the startup dwell in seconds for state 2'b00 (off).
REQ-003 The block SHALL have parameter RED_S, default 30, meaning the red dwell in seconds for state 2'b01.
REQ-004 The block SHALL have parameter GREEN_S, default 25, meaning the green dwell in seconds for state 2'b10.
REQ-005 The block SHALL have parameter YELLOW_S, default 5, meaning the yellow dwell in seconds for state 2'b11.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, width 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-008 The block SHALL have port enable, input, width 1: 1 = timing runs, 0 = timing paused.
REQ-009 The block SHALL have port state, input, width 2, the current light state fed back from the downstream sequencer.
REQ-010 The block SHALL have port mux_out, output, width 1, the registered one-cycle advance pulse to the downstream sequencer.
REQ-011 The block SHALL have port sec_tick, output, width 1, the registered one-cycle pulse at each one-second boundary.
REQ-012 The block SHALL have port remaining, output, width 8, the seconds left in the current phase, for display.

Function
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 while enable=1, wrap to 0, and pulse sec_tick for 1 cycle on each wrap; with enable=0 it holds and sec_tick=0.
REQ-014 The block SHALL register state into state_q every cycle; state != state_q is a phase change.
REQ-015 On a phase change, remaining SHALL load dur(state) on the next edge, and the prescaler SHALL clear to 0.
REQ-016 dur() SHALL map 00->OFF_S, 01->RED_S, 10->GREEN_S, 11->YELLOW_S; any duration of 0 is treated as 1, and values above 255 saturate to 255.
REQ-017 On sec_tick with remaining>1 and no phase change, remaining SHALL decrement by 1.
REQ-018 On sec_tick with remaining==1 and no phase change, remaining SHALL go to 0 and mux_out SHALL be 1 for exactly the following cycle.
REQ-019 When remaining==0, the block SHALL ignore further sec_tick, keep mux_out=0, and wait for a phase change; it never wraps below 0.
REQ-020 A phase change in the same cycle as sec_tick SHALL take priority: reload, no decrement, no mux_out.
REQ-021 mux_out SHALL never be high in two consecutive cycles, and consecutive pulses SHALL be at least 2 cycles apart (rising-edge safe downstream).
REQ-022 If enable drops mid-phase, remaining and the prescaler SHALL freeze; phase-change reloads SHALL still occur while paused.

Reset
REQ-023 With rst_n=0 at a clk edge: prescaler=0, sec_tick=0, mux_out=0, state_q=2'b00, remaining=dur(2'b00).
REQ-024 Reset mid-phase SHALL abandon the count immediately, with no pulse emitted during or on release of reset.

Configuration
REQ-025 With macro PHASE_TIMER_FAST_SIM_EN defined, the effective divisor SHALL be 4 regardless of TICK_DIV; without it, the divisor SHALL be TICK_DIV.

Verification
REQ-026 Setup: FAST_SIM_EN, OFF_S=2, enable=1, state held 00 after reset -> sec_tick every 4 cycles; remaining 2->1->0; single mux_out pulse at cycle 9 after reset release; then idle at 0.
REQ-027 Closed loop with the sequencer, RED_S=3, GREEN_S=2, YELLOW_S=1 -> state sequence 00,01,10,11,01 with dwells of 12/8/4 ticks-cycles; exactly one pulse per phase.
REQ-028 enable=0 for 10 cycles with remaining=2 -> remaining stays 2 and sec_tick/mux_out stay 0; resumes from the same prescaler count.
REQ-029 Force state 01->10 in the same cycle as sec_tick -> remaining=GREEN_S, no mux_out.
REQ-030 rst_n=0 when remaining==1, one cycle before expiry -> mux_out stays 0; remaining=OFF_S after reset.
